// File: rtl/dsp_frame_scheduler_if.sv
// Signal bundle between the frame scheduler and its environment: ADC capture
// inputs, the single-channel engine handshake, and the committed DAC pair.
interface dsp_frame_scheduler_if #(
  parameter int WS    = 16,
  parameter int DIV_W = 4
);
  logic             iLRCK;
  logic [WS-1:0]    iL;
  logic [WS-1:0]    iR;
  logic [DIV_W-1:0] iDivSel;
  logic             iBypass;

  // Engine handshake: oEngStart is a one-cycle job request carrying oEngChn and
  // oEngDat, which stay stable until the job ends; the engine answers with a
  // one-cycle iEngDone carrying iEngDat. A done seen while no job is pending is
  // dropped. oValid is a one-cycle strobe with no back-pressure.
  logic             oEngStart;
  logic             oEngChn;
  logic [WS-1:0]    oEngDat;
  logic             iEngDone;
  logic [WS-1:0]    iEngDat;

  logic [WS-1:0]    oL;
  logic [WS-1:0]    oR;
  logic             oValid;
  logic             oBusy;
  logic             oOverrun;
  logic             oTimeout;

  modport slave (
    input  iLRCK, iL, iR, iDivSel, iBypass, iEngDone, iEngDat,
    output oEngStart, oEngChn, oEngDat, oL, oR, oValid, oBusy, oOverrun, oTimeout
  );

  modport master (
    output iLRCK, iL, iR, iDivSel, iBypass, iEngDone, iEngDat,
    input  oEngStart, oEngChn, oEngDat, oL, oR, oValid, oBusy, oOverrun, oTimeout
  );
endinterface

// File: rtl/dsp_frame_scheduler.sv
// Per-frame sequencer: detects LR-clock frames, applies the undersampling divider,
// time-shares one DSP engine between L and R, and commits the processed pair.
module dsp_frame_scheduler #(
  parameter int WS      = 16,
  parameter int DIV_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 iCLK_50,
  input  logic                 iRST,
  dsp_frame_scheduler_if.slave bus,
  output logic [2:0]           o_state
);

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_L = 3'd1,
    WAIT_L  = 3'd2,
    START_R = 3'd3,
    WAIT_R  = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_s1, r_s2, r_s3;
  logic             w_strobe;
  logic             w_accept;
  logic [DIV_W-1:0] r_fcnt;
  logic [WS-1:0]    r_cap_l, r_cap_r;
  logic [WS-1:0]    r_res_l, r_res_r;
  logic [WS-1:0]    w_res_l, w_res_r;
  logic [WS-1:0]    r_out_l, r_out_r;
  logic [TW-1:0]    r_tcnt;
  logic             r_overrun;
  logic             r_timeout;
  logic             w_tmo;

  assign w_strobe = r_s2 & ~r_s3;
  // The >= (not ==) keeps the divider sane when iDivSel drops below the count.
  assign w_accept = w_strobe && (r_state == IDLE) && (r_fcnt >= bus.iDivSel);

  always_comb begin
    w_next  = r_state;
    w_res_l = r_res_l;
    w_res_r = r_res_r;
    w_tmo   = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_next = bus.iBypass ? COMMIT : START_L;
      START_L: w_next = WAIT_L;
      WAIT_L: begin
        if (bus.iEngDone) begin
          w_res_l = bus.iEngDat;
          w_next  = START_R;
        end else if (r_tcnt == T_LAST) begin
          w_res_l = r_cap_l;
          w_tmo   = 1'b1;
          w_next  = START_R;
        end
      end
      START_R: w_next = WAIT_R;
      WAIT_R: begin
        if (bus.iEngDone) begin
          w_res_r = bus.iEngDat;
          w_next  = COMMIT;
        end else if (r_tcnt == T_LAST) begin
          w_res_r = r_cap_r;
          w_tmo   = 1'b1;
          w_next  = COMMIT;
        end
      end
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      r_state   <= IDLE;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_fcnt    <= '0;
      r_cap_l   <= '0;
      r_cap_r   <= '0;
      r_res_l   <= '0;
      r_res_r   <= '0;
      r_out_l   <= '0;
      r_out_r   <= '0;
      r_tcnt    <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s1    <= bus.iLRCK;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_res_l <= w_res_l;
      r_res_r <= w_res_r;
      if (w_strobe) begin
        if (r_state == IDLE) begin
          r_cap_l <= bus.iL;
          r_cap_r <= bus.iR;
          r_fcnt  <= (r_fcnt >= bus.iDivSel) ? '0 : r_fcnt + 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      if (r_state == START_L || r_state == START_R) begin
        r_tcnt <= '0;
      end else if (r_state == WAIT_L || r_state == WAIT_R) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_tmo) r_timeout <= 1'b1;
      // Output pair is loaded on entry to COMMIT so it is already valid under oValid.
      if (r_state == IDLE && w_next == COMMIT) begin
        r_out_l <= bus.iL;
        r_out_r <= bus.iR;
      end else if (r_state == WAIT_R && w_next == COMMIT) begin
        r_out_l <= w_res_l;
        r_out_r <= w_res_r;
      end
    end
  end

  always_comb begin
    bus.oEngDat = '0;
    if (r_state == START_L || r_state == WAIT_L) bus.oEngDat = r_cap_l;
    else if (r_state == START_R || r_state == WAIT_R) bus.oEngDat = r_cap_r;
  end

  assign bus.oEngStart = (r_state == START_L) || (r_state == START_R);
  assign bus.oEngChn   = (r_state == START_R) || (r_state == WAIT_R);
  assign bus.oL        = r_out_l;
  assign bus.oR        = r_out_r;
  assign bus.oValid    = (r_state == COMMIT);
  assign bus.oBusy     = (r_state != IDLE);
  assign bus.oOverrun  = r_overrun;
  assign bus.oTimeout  = r_timeout;
  assign o_state       = r_state;

endmodule

// File: tb/tb_dsp_frame_scheduler.sv
// Bench for dsp_frame_scheduler: directed frames, a reactive engine model, and a
// negedge monitor that checks starts, committed pairs and status probes.
module tb_dsp_frame_scheduler;

  localparam int WS      = 16;
  localparam int DIV_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int STAT_W  = 9 + 3 * WS;
  localparam int EXP_W   = 32 + 2 * WS;
  localparam int SEXP_W  = 32 + 1 + WS;
  localparam logic [STAT_W-1:0] FLAG_MASK = {3'b000, 6'b111111, {(3 * WS){1'b0}}};
  localparam logic [STAT_W-1:0] ALL_MASK  = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] ALL_ZERO  = {STAT_W{1'b0}};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_frame_scheduler_if #(.WS(WS), .DIV_W(DIV_W)) bus ();
  logic [2:0] dbg_state;

  dsp_frame_scheduler #(.WS(WS), .DIV_W(DIV_W), .TIMEOUT(TIMEOUT)) u_dut (
    .iCLK_50 (clk),
    .iRST    (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // scoreboard state
  logic [EXP_W-1:0]  exp_q[$];
  logic [SEXP_W-1:0] exp_s_q[$];
  logic [STAT_W-1:0] probe_exp_q[$];
  logic [STAT_W-1:0] probe_mask_q[$];
  string             probe_name_q[$];
  int                n_pass;
  int                n_total;
  bit                fin_req;
  bit                mon_done;

  // engine model configuration (delay in cycles after start; 0 = never answers)
  int                eng_dl = 1;
  int                eng_dr = 1;
  int unsigned       pend_cyc;
  logic [WS-1:0]     pend_dat = '0;
  int unsigned       man_cyc;
  logic [WS-1:0]     man_dat = '0;

  logic [DIV_W-1:0]  m_fcnt = '0;
  logic              m_overrun = 1'b0;
  logic              m_timeout = 1'b0;

  function automatic logic [STAT_W-1:0] flags(input logic busy, input logic ovr,
                                               input logic tmo, input logic [2:0] st);
    return {3'b000, busy, ovr, tmo, st, {(3 * WS){1'b0}}};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input logic [STAT_W-1:0] m,
                       input logic [STAT_W-1:0] e);
    probe_name_q.push_back(name);
    probe_mask_q.push_back(m);
    probe_exp_q.push_back(e);
  endtask

  // driver: one LR-clock rise with its samples; the model predicts the response
  task automatic send_frame(input logic [WS-1:0] l, input logic [WS-1:0] r,
                            input logic byp, input int dl, input int dr,
                            input bit overlap, input bit abort, input int gap);
    int unsigned   k;
    bit            acc;
    bit            ok_l, ok_r;
    int            eff_l, eff_r;
    logic [WS-1:0] res_l, res_r;
    if (!overlap) begin
      eng_dl = dl;
      eng_dr = dr;
    end
    bus.iL      = l;
    bus.iR      = r;
    bus.iBypass = byp;
    bus.iLRCK   = 1'b1;
    k = cyc + 2;
    if (overlap) begin
      m_overrun = 1'b1;
    end else begin
      acc = (m_fcnt >= bus.iDivSel);
      m_fcnt = acc ? '0 : m_fcnt + 1'b1;
      if (acc && byp) begin
        exp_q.push_back({k + 1, l, r});
      end else if (acc) begin
        ok_l  = (dl > 0) && (dl <= TIMEOUT);
        ok_r  = (dr > 0) && (dr <= TIMEOUT);
        eff_l = ok_l ? dl : TIMEOUT;
        eff_r = ok_r ? dr : TIMEOUT;
        res_l = ok_l ? l + 1'b1 : l;
        res_r = ok_r ? r + 1'b1 : r;
        if (!ok_l) m_timeout = 1'b1;
        if (!ok_r && !abort) m_timeout = 1'b1;
        exp_s_q.push_back({k + 1, 1'b0, l});
        exp_s_q.push_back({k + 2 + eff_l, 1'b1, r});
        if (!abort) exp_q.push_back({k + 3 + eff_l + eff_r, res_l, res_r});
      end
    end
    tick(4);
    bus.iLRCK = 1'b0;
    tick(gap);
  endtask

  // engine done driver
  initial begin : eng_drv
    bus.iEngDone = 1'b0;
    bus.iEngDat  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (man_cyc == cyc) begin
        bus.iEngDone = 1'b1;
        bus.iEngDat  = man_dat;
      end else if (pend_cyc == cyc) begin
        bus.iEngDone = 1'b1;
        bus.iEngDat  = pend_dat;
      end else begin
        bus.iEngDone = 1'b0;
        bus.iEngDat  = '0;
      end
    end
  end

  // monitor: engine starts, committed pairs, status probes
  initial begin : monitor
    logic [STAT_W-1:0] stat, pm, pe;
    logic [EXP_W-1:0]  e;
    logic [SEXP_W-1:0] se;
    string             pn;
    int                d;
    forever begin
      @(negedge clk);
      stat = {bus.oValid, bus.oEngStart, bus.oEngChn, bus.oBusy, bus.oOverrun,
              bus.oTimeout, dbg_state, bus.oEngDat, bus.oL, bus.oR};
      if (bus.oEngStart) begin
        d = bus.oEngChn ? eng_dr : eng_dl;
        if (d > 0) begin
          pend_cyc = cyc + d;
          pend_dat = bus.oEngDat + 1'b1;
        end
        n_total++;
        if (exp_s_q.size() == 0) begin
          $display("FAIL eng_start: got start cyc=%0d chn=%0d dat=%h, required none",
                   cyc, bus.oEngChn, bus.oEngDat);
        end else begin
          se = exp_s_q.pop_front();
          if ({cyc, bus.oEngChn, bus.oEngDat} == se) n_pass++;
          else $display("FAIL eng_start: got cyc=%0d chn=%0d dat=%h, required cyc=%0d chn=%0d dat=%h",
                        cyc, bus.oEngChn, bus.oEngDat, se[SEXP_W-1 -: 32], se[WS], se[WS-1:0]);
        end
      end
      if (bus.oValid) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_valid: got oValid cyc=%0d oL=%h oR=%h, required none",
                   cyc, bus.oL, bus.oR);
        end else begin
          e = exp_q.pop_front();
          if ({cyc, bus.oL, bus.oR} == e) n_pass++;
          else $display("FAIL out_valid: got cyc=%0d oL=%h oR=%h, required cyc=%0d oL=%h oR=%h",
                        cyc, bus.oL, bus.oR, e[EXP_W-1 -: 32], e[2*WS-1 -: WS], e[WS-1:0]);
        end
      end
      while (probe_exp_q.size() > 0) begin
        pn = probe_name_q.pop_front();
        pm = probe_mask_q.pop_front();
        pe = probe_exp_q.pop_front();
        n_total++;
        if ((stat & pm) == (pe & pm)) n_pass++;
        else $display("FAIL %s: got status=%h, required %h under mask %h", pn, stat & pm, pe & pm, pm);
      end
      if (fin_req && !mon_done) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_total++;
          $display("FAIL out_valid: got no oValid, required cyc=%0d oL=%h oR=%h",
                   e[EXP_W-1 -: 32], e[2*WS-1 -: WS], e[WS-1:0]);
        end
        while (exp_s_q.size() > 0) begin
          se = exp_s_q.pop_front();
          n_total++;
          $display("FAIL eng_start: got no start, required cyc=%0d chn=%0d dat=%h",
                   se[SEXP_W-1 -: 32], se[WS], se[WS-1:0]);
        end
        mon_done = 1'b1;
      end
    end
  end

  // directed stimulus
  initial begin : main
    logic [WS-1:0] vl, vr;
    bus.iLRCK   = 1'b0;
    bus.iL      = '0;
    bus.iR      = '0;
    bus.iDivSel = '0;
    bus.iBypass = 1'b0;
    rst = 1'b1;
    tick(3);
    probe("reset_all_zero", ALL_MASK, ALL_ZERO);
    rst = 1'b0;
    tick(2);

    send_frame(16'h1234, 16'hFEDC, 1'b0, 1, 1, 1'b0, 1'b0, 30);
    send_frame(16'h0001, 16'h8000, 1'b0, 3, 5, 1'b0, 1'b0, 30);
    send_frame(16'hFFFF, 16'h7FFF, 1'b0, 2, 1, 1'b0, 1'b0, 30);
    send_frame(16'h8000, 16'h7FFF, 1'b1, 1, 1, 1'b0, 1'b0, 30);

    send_frame(16'h0AA0, 16'h0BB0, 1'b0, TIMEOUT, 1, 1'b0, 1'b0, 30);
    probe("no_timeout_on_expiry_done", FLAG_MASK, flags(1'b0, m_overrun, m_timeout, 3'd0));
    send_frame(16'h1111, 16'h2222, 1'b0, 0, 2, 1'b0, 1'b0, 30);
    probe("timeout_sticky", FLAG_MASK, flags(1'b0, m_overrun, m_timeout, 3'd0));
    send_frame(16'h3333, 16'h4444, 1'b0, TIMEOUT + 1, TIMEOUT, 1'b0, 1'b0, 30);

    bus.iDivSel = 4'd3;
    for (int i = 0; i < 12; i++) begin
      vl = WS'(32'h0100 + i);
      vr = WS'(32'h0200 + i);
      send_frame(vl, vr, 1'b0, 1, 1, 1'b0, 1'b0, 14);
    end
    send_frame(16'h0C01, 16'h0D01, 1'b0, 1, 1, 1'b0, 1'b0, 14);
    send_frame(16'h0C02, 16'h0D02, 1'b0, 1, 1, 1'b0, 1'b0, 14);
    bus.iDivSel = 4'd1;
    send_frame(16'h0C03, 16'h0D03, 1'b0, 1, 1, 1'b0, 1'b0, 14);

    bus.iDivSel = 4'd0;
    send_frame(16'h6001, 16'h7001, 1'b0, 0, 0, 1'b0, 1'b0, 4);
    bus.iDivSel = 4'd1;
    send_frame(16'h6BAD, 16'h7BAD, 1'b0, 1, 1, 1'b1, 1'b0, 30);
    probe("overrun_sticky", FLAG_MASK, flags(1'b0, m_overrun, m_timeout, 3'd0));
    send_frame(16'h6002, 16'h7002, 1'b0, 1, 1, 1'b0, 1'b0, 14);
    send_frame(16'h6003, 16'h7003, 1'b0, 1, 1, 1'b0, 1'b0, 14);
    probe("flags_held_before_reset", FLAG_MASK, flags(1'b0, m_overrun, m_timeout, 3'd0));

    bus.iDivSel = 4'd0;
    send_frame(16'h4321, 16'h8765, 1'b0, 1, 0, 1'b0, 1'b1, 2);
    probe("in_wait_r_before_reset", FLAG_MASK, flags(1'b1, m_overrun, m_timeout, 3'd4));
    rst = 1'b1;
    tick(1);
    probe("reset_mid_job_all_zero", ALL_MASK, ALL_ZERO);
    rst = 1'b0;
    m_fcnt    = '0;
    m_overrun = 1'b0;
    m_timeout = 1'b0;
    man_dat   = 16'hDEAD;
    man_cyc   = cyc + 1;
    tick(4);
    probe("late_done_ignored", FLAG_MASK, flags(1'b0, m_overrun, m_timeout, 3'd0));
    send_frame(16'h5A5A, 16'hA5A5, 1'b0, 1, 2, 1'b0, 1'b0, 30);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
    #1;
    if (!mon_done) $display("FAIL monitor_drain: got no final drain, required drain within 10 cycles");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
